// File: rtl/transmit_arbiter.sv
// Four-requester round-robin arbiter feeding one serial transmitter.
// One-entry holding slot per requester; lost frames are counted.
module transmit_arbiter #(
  parameter int N_REQ          = 4,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic                  clk_96MHz,
  input  logic                  reset_n,
  input  logic [N_REQ-1:0]      req_ready,
  input  logic [N_REQ-1:0][16:0] req_pulse_id_0,
  input  logic [N_REQ-1:0][16:0] req_pulse_id_1,
  input  logic [N_REQ-1:0][16:0] req_polynomial,
  output logic [N_REQ-1:0]      req_release,
  output logic                  tx_valid,
  output logic [1:0]            tx_source,
  output logic [50:0]           tx_payload,
  input  logic                  tx_ack,
  output logic [7:0]            drop_count
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    SEND,
    RELEASE
  } state_t;

  state_t state;
  state_t state_nx;

  logic [N_REQ-1:0]       full;
  logic [N_REQ-1:0][50:0] data;
  logic [IW-1:0]          grant;
  logic [IW-1:0]          last_grant;
  logic [IW-1:0]          pick;
  logic                   pick_ok;
  logic [CW-1:0]          cnt;
  logic [N_REQ-1:0]       releasing;
  logic [N_REQ-1:0]       capture;
  logic [N_REQ-1:0]       drop;
  logic                   timeout;
  logic [3:0]             n_drop;
  logic [8:0]             drop_sum;

  // A slot in its RELEASE cycle counts as empty, so a new frame refills it.
  always_comb begin
    releasing = '0;
    if (state == RELEASE) releasing[grant] = 1'b1;
    capture = req_ready & (~full | releasing);
    drop    = req_ready & full & ~releasing;
  end

  // Smallest offset from last_grant+1 wins: iterate offsets high to low.
  always_comb begin
    int j;
    pick    = '0;
    pick_ok = 1'b0;
    j       = 0;
    for (int k = N_REQ; k >= 1; k--) begin
      j = (int'(last_grant) + k) % N_REQ;
      if (full[j]) begin
        pick    = IW'(j);
        pick_ok = 1'b1;
      end
    end
  end

  assign timeout = (state == SEND) && !tx_ack &&
                   (cnt == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    n_drop = {3'b000, timeout};
    for (int i = 0; i < N_REQ; i++) begin
      n_drop = n_drop + {3'b000, drop[i]};
    end
    drop_sum = {1'b0, drop_count} + {5'b00000, n_drop};
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (pick_ok) state_nx = GRANT;
      GRANT:   state_nx = SEND;
      SEND:    if (tx_ack || timeout) state_nx = RELEASE;
      RELEASE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign tx_valid = (state == SEND);

  always_ff @(posedge clk_96MHz or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_ff @(posedge clk_96MHz or negedge reset_n) begin
    if (!reset_n) begin
      full        <= '0;
      data        <= '0;
      req_release <= '0;
    end else begin
      req_release <= req_ready;
      for (int i = 0; i < N_REQ; i++) begin
        if (capture[i]) begin
          full[i] <= 1'b1;
          data[i] <= {req_pulse_id_0[i],
                      req_pulse_id_1[i],
                      req_polynomial[i]};
        end else if (releasing[i]) begin
          full[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_96MHz or negedge reset_n) begin
    if (!reset_n) begin
      grant      <= '0;
      last_grant <= IW'(N_REQ - 1);
      cnt        <= '0;
      tx_source  <= '0;
      tx_payload <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pick_ok) grant <= pick;
        end
        GRANT: begin
          tx_payload <= data[grant];
          tx_source  <= 2'(grant);
          cnt        <= '0;
        end
        SEND: begin
          cnt <= cnt + CW'(1);
        end
        RELEASE: begin
          last_grant <= grant;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_96MHz or negedge reset_n) begin
    if (!reset_n)             drop_count <= '0;
    else if (drop_sum > 9'd255) drop_count <= 8'd255;
    else                      drop_count <= drop_sum[7:0];
  end

endmodule

// File: tb/tb_transmit_arbiter.sv
// Bench for transmit_arbiter: vector table plus corner-case sequences,
// frames scored against a queue of expected {source, payload}.
module tb_transmit_arbiter;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [3:0]       req_ready;
  logic [3:0][16:0] req_pulse_id_0;
  logic [3:0][16:0] req_pulse_id_1;
  logic [3:0][16:0] req_polynomial;
  logic [3:0]       req_release;
  logic             tx_valid;
  logic [1:0]       tx_source;
  logic [50:0]      tx_payload;
  logic             tx_ack;
  logic [7:0]       drop_count;

  always #5 clk = ~clk;

  transmit_arbiter #(
    .N_REQ(4),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk_96MHz(clk),
    .reset_n(reset_n),
    .req_ready(req_ready),
    .req_pulse_id_0(req_pulse_id_0),
    .req_pulse_id_1(req_pulse_id_1),
    .req_polynomial(req_polynomial),
    .req_release(req_release),
    .tx_valid(tx_valid),
    .tx_source(tx_source),
    .tx_payload(tx_payload),
    .tx_ack(tx_ack),
    .drop_count(drop_count)
  );

  typedef struct {
    logic [1:0]  idx;
    logic [16:0] p0;
    logic [16:0] p1;
    logic [16:0] poly;
    logic [50:0] exp_payload;
    logic [3:0]  exp_release;
  } vec_t;

  typedef struct {
    logic [1:0]  src;
    logic [50:0] payload;
  } exp_t;

  exp_t        sb[$];
  vec_t        vecs[4];
  int          n_chk = 0;
  int          n_pass = 0;
  int          unstable = 0;
  int          rel_seen = 0;
  int          rel_exp = 0;
  bit          mon_en = 1'b1;
  logic        prev_valid = 1'b0;
  logic [1:0]  held_src = '0;
  logic [50:0] held_pay = '0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", name, act, exp);
  endtask

  task automatic monitor();
    exp_t e;
    for (int i = 0; i < 4; i++) if (req_release[i]) rel_seen++;
    if (tx_valid && !prev_valid && mon_en) begin
      if (sb.size() == 0) begin
        chk("unexpected_frame", 64'(tx_source), 64'hFF);
      end else begin
        e = sb.pop_front();
        chk("tx_source", 64'(tx_source), 64'(e.src));
        chk("tx_payload", 64'(tx_payload), 64'(e.payload));
      end
    end
    if (tx_valid && prev_valid &&
        (tx_source !== held_src || tx_payload !== held_pay))
      unstable++;
    held_src   = tx_source;
    held_pay   = tx_payload;
    prev_valid = tx_valid;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    monitor();
  endtask

  task automatic set_data(input int i, input logic [16:0] a,
                          input logic [16:0] b, input logic [16:0] c);
    req_pulse_id_0[i] = a;
    req_pulse_id_1[i] = b;
    req_polynomial[i] = c;
  endtask

  task automatic push(input int i, input logic [16:0] a,
                      input logic [16:0] b, input logic [16:0] c);
    exp_t e;
    e.src     = 2'(i);
    e.payload = {a, b, c};
    sb.push_back(e);
  endtask

  task automatic pulse(input logic [3:0] m);
    req_ready = m;
    rel_exp += $countones(m);
    tick();
    req_ready = '0;
  endtask

  task automatic wait_valid(input int max);
    int k = 0;
    while (!tx_valid && k < max) begin
      tick();
      k++;
    end
    if (!tx_valid) chk("wait_valid_timeout", 64'(0), 64'(1));
  endtask

  task automatic ack();
    tx_ack = 1'b1;
    tick();
    tx_ack = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    int len;
    reset_n        = 1'b0;
    req_ready      = '0;
    req_pulse_id_0 = '0;
    req_pulse_id_1 = '0;
    req_polynomial = '0;
    tx_ack         = 1'b0;

    vecs[0] = '{2'd2, 17'h12345, 17'h00ABC, 17'h1FFFF,
                {17'h12345, 17'h00ABC, 17'h1FFFF}, 4'b0100};
    vecs[1] = '{2'd0, 17'h00001, 17'h10000, 17'h00000,
                {17'h00001, 17'h10000, 17'h00000}, 4'b0001};
    vecs[2] = '{2'd3, 17'h1FFFF, 17'h1FFFF, 17'h1FFFF,
                {17'h1FFFF, 17'h1FFFF, 17'h1FFFF}, 4'b1000};
    vecs[3] = '{2'd1, 17'h0AAAA, 17'h15555, 17'h00123,
                {17'h0AAAA, 17'h15555, 17'h00123}, 4'b0010};

    tick();
    tick();
    chk("rst_tx_valid", 64'(tx_valid), 64'(0));
    chk("rst_tx_source", 64'(tx_source), 64'(0));
    chk("rst_tx_payload", 64'(tx_payload), 64'(0));
    chk("rst_release", 64'(req_release), 64'(0));
    chk("rst_drop", 64'(drop_count), 64'(0));
    reset_n = 1'b1;

    // single frames, first one on the first edge after reset
    foreach (vecs[v]) begin
      set_data(int'(vecs[v].idx), vecs[v].p0, vecs[v].p1, vecs[v].poly);
      push(int'(vecs[v].idx), vecs[v].exp_payload[50:34],
           vecs[v].exp_payload[33:17], vecs[v].exp_payload[16:0]);
      pulse(4'(1) << vecs[v].idx);
      chk("release", 64'(req_release), 64'(vecs[v].exp_release));
      tick();
      chk("grant_no_valid", 64'(tx_valid), 64'(0));
      tick();
      chk("latency_valid", 64'(tx_valid), 64'(1));
      ack();
      chk("valid_fall", 64'(tx_valid), 64'(0));
      tick();
      tx_ack = 1'b1;
      tick();
      tx_ack = 1'b0;
      repeat (3) tick();
      chk("slot_empty", 64'(tx_valid), 64'(0));
    end
    chk("no_drops", 64'(drop_count), 64'(0));

    // round robin after reset: 0,1,2,3 twice
    do_reset();
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < 4; i++) begin
        set_data(i, 17'(17'h100 * (b + 1) + i), 17'(i * 3), 17'(17'h1F000 + i));
        push(i, 17'(17'h100 * (b + 1) + i), 17'(i * 3), 17'(17'h1F000 + i));
      end
      pulse(4'hF);
      chk("rr_release", 64'(req_release), 64'hF);
      for (int f = 0; f < 4; f++) begin
        wait_valid(10);
        repeat (4) tick();
        ack();
      end
    end

    // overflow on slot 1 while slot 0 is granted
    set_data(0, 17'h0A0A0, 17'h00001, 17'h00002);
    set_data(1, 17'h0B1B1, 17'h00003, 17'h00004);
    push(0, 17'h0A0A0, 17'h00001, 17'h00002);
    push(1, 17'h0B1B1, 17'h00003, 17'h00004);
    pulse(4'b0011);
    tick();
    set_data(1, 17'h1DEAD, 17'h1BEEF, 17'h00BAD);
    pulse(4'b0010);
    chk("ovf_drop", 64'(drop_count), 64'(1));
    chk("ovf_release", 64'(req_release), 64'b0010);
    wait_valid(10);
    ack();
    wait_valid(10);
    ack();

    // timeout on slot 2, then slot 3 is served
    set_data(2, 17'h02222, 17'h00022, 17'h00002);
    set_data(3, 17'h03333, 17'h00033, 17'h00003);
    push(2, 17'h02222, 17'h00022, 17'h00002);
    push(3, 17'h03333, 17'h00033, 17'h00003);
    pulse(4'b1100);
    wait_valid(10);
    len = 0;
    while (tx_valid && len < 40) begin
      len++;
      tick();
    end
    chk("timeout_len", 64'(len), 64'(16));
    chk("timeout_drop", 64'(drop_count), 64'(2));
    wait_valid(10);
    ack();

    // refill of slot 0 in its RELEASE cycle
    set_data(0, 17'h0C0C0, 17'h0C0C0, 17'h0C0C0);
    push(0, 17'h0C0C0, 17'h0C0C0, 17'h0C0C0);
    pulse(4'b0001);
    wait_valid(10);
    ack();
    set_data(0, 17'h0D0D0, 17'h00D0D, 17'h1D000);
    push(0, 17'h0D0D0, 17'h00D0D, 17'h1D000);
    pulse(4'b0001);
    chk("coll_drop", 64'(drop_count), 64'(2));
    chk("coll_release", 64'(req_release), 64'b0001);
    wait_valid(10);
    ack();
    repeat (3) tick();
    chk("coll_empty", 64'(tx_valid), 64'(0));

    // reset in the middle of SEND
    set_data(1, 17'h0E0E0, 17'h0E0E0, 17'h0E0E0);
    push(1, 17'h0E0E0, 17'h0E0E0, 17'h0E0E0);
    pulse(4'b0010);
    wait_valid(10);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(tx_valid), 64'(0));
    chk("mid_rst_source", 64'(tx_source), 64'(0));
    chk("mid_rst_payload", 64'(tx_payload), 64'(0));
    chk("mid_rst_drop", 64'(drop_count), 64'(0));
    chk("mid_rst_release", 64'(req_release), 64'(0));
    tick();
    tick();
    reset_n = 1'b1;
    set_data(3, 17'h0F0F0, 17'h00F0F, 17'h1F0F0);
    push(3, 17'h0F0F0, 17'h00F0F, 17'h1F0F0);
    pulse(4'b1000);
    chk("post_rst_release", 64'(req_release), 64'b1000);
    wait_valid(10);
    ack();
    repeat (2) tick();

    // drop counter saturation under sustained overload
    mon_en = 1'b0;
    for (int n = 0; n < 100; n++) pulse(4'hF);
    chk("drop_saturate", 64'(drop_count), 64'(255));
    pulse(4'hF);
    chk("drop_hold", 64'(drop_count), 64'(255));
    tick();

    chk("sb_empty", 64'(sb.size()), 64'(0));
    chk("payload_stable", 64'(unstable), 64'(0));
    chk("release_count", 64'(rel_seen), 64'(rel_exp));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/transmit_arbiter.md
TRANSMIT_ARBITER -- requirements
Module: transmit_arbiter

Parameters
REQ-001 N_REQ, default 4, number of pulse-identifier requesters sharing one serial transmitter; fixed at 4 for this revision.
REQ-002 TIMEOUT_CYCLES, default 1048576, clk_96MHz cycles allowed for tx_ack before the frame is abandoned.

Interface
REQ-003 clk_96MHz  input  1  sole clock; all logic on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 req_ready  input  4  per-requester one-cycle pulse: frame available on that requester's data bus.
REQ-006 req_pulse_id_0  input  4x17  per-requester first decoded pulse id.
REQ-007 req_pulse_id_1  input  4x17  per-requester second decoded pulse id.
REQ-008 req_polynomial  input  4x17  per-requester polynomial.
REQ-009 req_release  output  4  per-requester one-cycle pulse that re-arms that pulse identifier.
REQ-010 tx_valid  output  1  frame presented to the transmitter.
REQ-011 tx_source  output  2  index of the requester owning the presented frame.
REQ-012 tx_payload  output  51  {pulse_id_0, pulse_id_1, polynomial} of the presented frame.
REQ-013 tx_ack  input  1  one-cycle pulse from the transmitter: frame consumed; already synchronous to clk_96MHz.
REQ-014 drop_count  output  8  saturating count of lost frames.

Function
REQ-015 Each requester SHALL have a one-entry holding buffer of 51 bits plus a full flag.
REQ-016 On req_ready[i] with slot i empty, the slot SHALL capture the data and set full on that edge.
REQ-017 On the cycle after each capture, req_release[i] SHALL pulse high for exactly one cycle.
REQ-018 On req_ready[i] with slot i full and not being released, the arbiter SHALL discard the new data.
REQ-019 On that discard, drop_count SHALL increment, saturating at 255.
REQ-020 On that discard, req_release[i] SHALL pulse on the next cycle.
REQ-021 The FSM SHALL have four states: IDLE, GRANT, SEND and RELEASE.
REQ-022 IDLE: if any slot is full, the FSM SHALL select one round-robin, searching from last_grant+1 modulo 4, and go to GRANT; otherwise it SHALL stay in IDLE.
REQ-023 GRANT: the FSM SHALL copy the selected slot into tx_payload and tx_source, start the timeout counter at 0, and go to SEND.
REQ-024 SEND: tx_valid SHALL be 1, and tx_payload and tx_source SHALL stay stable.
REQ-025 SEND: on tx_ack the FSM SHALL go to RELEASE.
REQ-026 SEND: when the counter reaches TIMEOUT_CYCLES-1 without tx_ack, drop_count SHALL increment (saturating) and the FSM SHALL go to RELEASE.
REQ-027 RELEASE: tx_valid SHALL be 0, the granted slot's full flag SHALL clear, last_grant SHALL take the granted index, and the FSM SHALL return to IDLE.
REQ-028 Latency: a capture into an empty arbiter while the FSM is in IDLE SHALL give tx_valid high 3 cycles after the req_ready edge (capture, GRANT, SEND).
REQ-029 req_ready[i] in the RELEASE cycle of slot i SHALL capture the new data, leaving the slot full, with no drop counted.
REQ-030 Simultaneous req_ready on several requesters SHALL be captured independently in the same cycle.
REQ-031 A capture into any slot other than the granted one SHALL NOT disturb tx_payload.
REQ-032 tx_ack outside SEND SHALL be ignored.
REQ-033 tx_valid SHALL never be asserted in IDLE, GRANT or RELEASE.
REQ-034 Each transmitted frame SHALL produce exactly one tx_valid high period.

Reset
REQ-035 On reset_n low, the FSM SHALL go to IDLE immediately and asynchronously.
REQ-036 On reset_n low, all full flags SHALL clear.
REQ-037 On reset_n low, last_grant SHALL be 3, so requester 0 is served first.
REQ-038 On reset_n low, tx_valid, tx_source, tx_payload, req_release and drop_count SHALL all be 0.
REQ-039 Reset asserted mid-SEND SHALL drop tx_valid at once, with no tx_ack expected and no drop counted.
REQ-040 After reset_n rises, the arbiter SHALL accept req_ready on the first clock edge.

Verification
REQ-041 Single frame: req_ready[2] with payload 0x1_2345/0x0_0ABC/0x1_FFFF -> release[2] pulses the next cycle; tx_valid rises 3 cycles after req_ready with tx_source=2 and the same payload; tx_ack -> tx_valid falls and the slot is empty.
REQ-042 Round robin: all four req_ready in one cycle; ack each frame 5 cycles after tx_valid rises -> tx_source order 0,1,2,3; a following burst of all four is again served 0,1,2,3.
REQ-043 Overflow: slot 1 full and not granted; second req_ready[1] -> drop_count 0->1, release[1] pulses, the original slot-1 payload is transmitted.
REQ-044 Timeout: TIMEOUT_CYCLES=16, no tx_ack -> tx_valid is high for exactly 16 cycles, drop_count increments, the next full slot is granted.
REQ-045 Release collision: req_ready[0] in slot 0's RELEASE cycle -> slot 0 is re-filled, drop_count is unchanged, the new frame is transmitted next.
REQ-046 Reset mid-SEND: reset_n low while tx_valid=1 -> all outputs are 0 in the same cycle; after release, a fresh req_ready[3] is served with tx_source=3.
